// File: rtl/alu_pipe_param.sv
// alu_pipe_param: two-stage pipelined ALU with NZCV flags and a chaining accumulator.
// S1 registers an accepted operand beat. S2 computes from S1 and holds the result
// until the consumer takes it. Both handshakes are valid/ready, and one op per cycle
// sustains when out_ready stays high.
module alu_pipe_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] acc
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // S1 operand stage
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic             s1_use_acc;

    // Handshake controls
    logic s1_load;
    logic s2_advance;

    // Datapath between S1 and S2
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH-1:0] res_c;
    logic             res_carry;
    logic             res_ovf;
    flags_t           res_flags;

    // S2 moves when it has work and its output slot is free or being emptied.
    // in_ready depends on rst and out_ready, never on in_valid.
    assign s2_advance = s1_valid && (!out_valid || out_ready);
    assign in_ready   = !rst && (!s1_valid || s2_advance);
    assign s1_load    = in_valid && in_ready;

    // Capture an accepted operand beat, or empty S1 when its beat moves into S2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the operand registers are reset along with s1_valid, even though
            // only s1_valid matters for control. That keeps X out of the S2 datapath
            // from time zero, which simplifies X-checking downstream.
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= OP_ADD;
            s1_use_acc <= 1'b0;
        end else if (s1_load) begin
            // NOTE: every register here is written with <=, so each flop samples
            // pre-edge values no matter how the always blocks are ordered.
            s1_valid   <= 1'b1;
            s1_a       <= a;
            s1_b       <= b;
            s1_op      <= op_e'(sel);
            s1_use_acc <= use_acc;
        end else if (s2_advance) begin
            s1_valid   <= 1'b0;
        end
    end

    // Operand A comes from the accumulator at compute time, so a use_acc op sees
    // the result of the op that computed just before it.
    assign op_a = s1_use_acc ? acc : s1_a;
    assign op_b = s1_b;
    assign sh   = s1_b[SHW-1:0];

    // Each extended vector carries one extra bit, which holds the carry, borrow or
    // last-shifted-out bit.
    assign add_ext = {1'b0, op_a} + {1'b0, op_b};
    assign sub_ext = {1'b0, op_a} - {1'b0, op_b};
    assign shl_ext = {1'b0, op_a} << sh;
    assign shr_ext = {op_a, 1'b0} >> sh;

    // Select the result, carry and overflow for the op waiting in S1
    always_comb begin
        // NOTE: every output of this block gets a default first. Then no opcode path
        // can leave a value unassigned, and no latch is inferred.
        res_c     = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (s1_op)
            OP_ADD: begin
                res_c     = add_ext[WIDTH-1:0];
                res_carry = add_ext[WIDTH];
                res_ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                            (add_ext[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c     = sub_ext[WIDTH-1:0];
                res_carry = sub_ext[WIDTH];
                res_ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                            (sub_ext[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: res_c = op_a & op_b;
            OP_OR:  res_c = op_a | op_b;
            OP_XOR: res_c = op_a ^ op_b;
            OP_SHL: begin
                res_c     = shl_ext[WIDTH-1:0];
                res_carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res_c     = shr_ext[WIDTH:1];
                res_carry = shr_ext[0];
            end
            OP_CMP: begin
                if (op_a > op_b) begin
                    res_c = WIDTH'(1);
                end else if (op_a == op_b) begin
                    res_c = WIDTH'(2);
                end
            end
        endcase
    end

    assign res_flags = '{n: res_c[WIDTH-1], z: (res_c == '0), c: res_carry, v: res_ovf};

    // Register the result and flags on each compute, and track the accumulator.
    // Under backpressure the registers hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            c         <= '0;
            flags     <= '0;
            acc       <= '0;
        end else if (s2_advance) begin
            out_valid <= 1'b1;
            c         <= res_c;
            flags     <= res_flags;
            acc       <= res_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb_alu_pipe_param: runs directed vectors, chaining, backpressure, mid-stream reset
// and randomized traffic against an arithmetic reference model with a result scoreboard.
module tb_alu_pipe_param;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic         use_acc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic [3:0]   flags;
    logic [W-1:0] acc;

    alu_pipe_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .use_acc   (use_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .flags     (flags),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    logic [11:0] exp_q[$];
    logic [7:0]  obs_q[$];
    logic [7:0]  model_acc = '0;
    logic [7:0]  last_c;
    logic [3:0]  last_flags;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [7:0] exp_c;
        logic [3:0] exp_f;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic. Returns {c[7:0], N, Z, C, V}.
    function automatic logic [11:0] model(input int ia, input int ib, input int op);
        int r, sa, sb, sr, sh;
        bit cy, v;
        cy = 0;
        v  = 0;
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        sh = ib % 8;
        case (op)
            0: begin r = ia + ib; cy = (r > 255); sr = sa + sb; v = (sr > 127 || sr < -128); r = r % 256; end
            1: begin r = (ia - ib + 256) % 256; cy = (ia < ib); sr = sa - sb; v = (sr > 127 || sr < -128); end
            2: r = ia & ib;
            3: r = ia | ib;
            4: r = ia ^ ib;
            5: begin r = ia * (1 << sh); cy = (sh != 0) && (((r / 256) % 2) == 1); r = r % 256; end
            6: begin r = ia / (1 << sh); cy = (sh != 0) && (((ia / (1 << (sh - 1))) % 2) == 1); end
            default: r = (ia > ib) ? 1 : ((ia == ib) ? 2 : 0);
        endcase
        return {8'(r), (r >= 128), (r == 0), cy, v};
    endfunction

    // Scoreboard, sampled 1 time unit before each rising edge
    initial begin
        logic [11:0] e;
        logic [7:0]  opa;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                exp_q.delete();
                model_acc = '0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_result", {c, flags}, e);
                        check("sb_acc", acc, e[11:4]);
                    end
                    pops++;
                    obs_q.push_back(c);
                    last_c     = c;
                    last_flags = flags;
                end
                if (in_valid && in_ready) begin
                    opa = use_acc ? model_acc : a;
                    e = model(int'(opa), int'(b), int'(sel));
                    model_acc = e[11:4];
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        sel      = 'x;
        use_acc  = 'x;
    endtask

    // Called at a falling edge. Returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] ts, input logic tu);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        sel      = ts;
        use_acc  = tu;
        for (int i = 0; i < 50 && !done; i++) begin
            #4;
            done = in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        if (!done) check("send_timeout", 0, 1);
        idle();
    endtask

    task automatic wait_pops(input int target, input string name);
        for (int i = 0; i < 60; i++) begin
            if (pops >= target) break;
            @(negedge clk);
        end
        if (pops < target) check(name, pops, target);
    endtask

    vec_t vecs[21];
    bit   rand_done;
    bit   bp_done;

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int n0;
        logic [7:0] c0;
        logic [3:0] f0;

        vecs = '{
            '{8'd200, 8'd100, 3'b000, 8'd44,  4'b0010},
            '{8'h80,  8'h01,  3'b001, 8'h7F,  4'b0001},
            '{8'd5,   8'd5,   3'b111, 8'd2,   4'b0000},
            '{8'd3,   8'd9,   3'b111, 8'd0,   4'b0100},
            '{8'h81,  8'd3,   3'b101, 8'h08,  4'b0000},
            '{8'h81,  8'd1,   3'b110, 8'h40,  4'b0010},
            '{8'hA5,  8'd0,   3'b101, 8'hA5,  4'b1000},
            '{8'hA5,  8'd8,   3'b110, 8'hA5,  4'b1000},
            '{8'hFF,  8'd1,   3'b000, 8'h00,  4'b0110},
            '{8'h7F,  8'd1,   3'b000, 8'h80,  4'b1001},
            '{8'd3,   8'd5,   3'b001, 8'hFE,  4'b1010},
            '{8'hF0,  8'h3C,  3'b010, 8'h30,  4'b0000},
            '{8'hF0,  8'h0F,  3'b011, 8'hFF,  4'b1000},
            '{8'hAA,  8'hAA,  3'b100, 8'h00,  4'b0100},
            '{8'd9,   8'd3,   3'b111, 8'd1,   4'b0000},
            '{8'h03,  8'd7,   3'b101, 8'h80,  4'b1010},
            '{8'h80,  8'd7,   3'b110, 8'h01,  4'b0000},
            '{8'h80,  8'h80,  3'b001, 8'h00,  4'b0100},
            '{8'h80,  8'h80,  3'b000, 8'h00,  4'b0111},
            '{8'h00,  8'h01,  3'b001, 8'hFF,  4'b1010},
            '{8'hC0,  8'd1,   3'b101, 8'h80,  4'b1010}
        };

        rst       = 1'b1;
        out_ready = 1'b1;
        idle();

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 0);
        check("rst_flags", flags, 0);
        check("rst_acc", acc, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);
        @(negedge clk);

        // Directed vectors
        foreach (vecs[i]) begin
            n0 = pops;
            send(vecs[i].a, vecs[i].b, vecs[i].sel, 1'b0);
            wait_pops(n0 + 1, "vec_timeout");
            check($sformatf("vec%0d_c", i), last_c, vecs[i].exp_c);
            check($sformatf("vec%0d_flags", i), last_flags, vecs[i].exp_f);
        end

        // Idle inputs are X. Nothing may leak out.
        repeat (3) @(negedge clk);
        check("no_x_idle", $isunknown({c, flags, acc, out_valid, in_ready}), 0);

        // Accumulator chain, issued back-to-back
        obs_q.delete();
        n0 = pops;
        send(8'd10, 8'd0, 3'b000, 1'b0);
        repeat (3) send(8'hxx, 8'd5, 3'b000, 1'b1);
        wait_pops(n0 + 4, "chain_timeout");
        if (obs_q.size() == 4) begin
            check("chain0", obs_q[0], 10);
            check("chain1", obs_q[1], 15);
            check("chain2", obs_q[2], 20);
            check("chain3", obs_q[3], 25);
        end else begin
            check("chain_count", obs_q.size(), 4);
        end
        check("chain_acc", acc, 25);

        // Backpressure: out_ready low while three beats are offered
        obs_q.delete();
        n0 = pops;
        out_ready = 1'b0;
        bp_done = 0;
        fork
            begin
                send(8'd1, 8'd2, 3'b000, 1'b0);
                send(8'd7, 8'd3, 3'b001, 1'b0);
                send(8'd6, 8'd6, 3'b111, 1'b0);
                bp_done = 1;
            end
        join_none
        for (int i = 0; i < 10; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        check("bp_out_valid", out_valid, 1);
        c0 = c;
        f0 = flags;
        for (int i = 0; i < 4; i++) begin
            check("bp_c_stable", c, c0);
            check("bp_flags_stable", flags, f0);
            check("bp_in_ready_low", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_pops(n0 + 3, "bp_timeout");
        for (int i = 0; i < 60 && !bp_done; i++) @(negedge clk);
        check("bp_sender_done", bp_done, 1);
        repeat (2) @(negedge clk);
        if (obs_q.size() == 3) begin
            check("bp_order0", obs_q[0], 3);
            check("bp_order1", obs_q[1], 4);
            check("bp_order2", obs_q[2], 2);
        end else begin
            check("bp_count", obs_q.size(), 3);
        end

        // Reset while both stages are full
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'd50; b = 8'd60; sel = 3'b000; use_acc = 1'b0;
        @(negedge clk);
        a = 8'd1; b = 8'd1;
        @(negedge clk);
        check("pre_rst_out_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_c", c, 0);
        check("mid_rst_flags", flags, 0);
        check("mid_rst_acc", acc, 0);
        check("mid_rst_in_ready", in_ready, 0);
        idle();
        @(negedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(negedge clk);
        n0 = pops;
        send(8'd20, 8'd22, 3'b000, 1'b0);
        check("lat_not_yet", out_valid, 0);
        @(negedge clk);
        check("lat_out_valid", out_valid, 1);
        check("lat_c", c, 42);
        wait_pops(n0 + 1, "lat_timeout");

        // Randomized traffic with random backpressure
        rand_done = 0;
        fork
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    send(pick(), pick(), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
                end
                rand_done = 1;
            end
        join
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
